// File: rtl/nn_pkg.sv
// Shared types and helpers for the nn inference-core feeder.
package nn_pkg;

    localparam int N_DEF = 200;
    localparam int W_DEF = 16;

    function automatic int num_words(input int n, input int w);
        return (n + w - 1) / w;
    endfunction

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        HOLD   = 2'd3
    } feeder_state_t;

endpackage

// File: rtl/nn_word_packer.sv
// Packs W-bit stream words into the N-bit nn input vector, one slot per accepted word.
module nn_word_packer
    import nn_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         accept,
    input  logic [W-1:0] s_data,
    output logic [N-1:0] nn_in,
    output logic         last_accepted
);

    localparam int NUM_WORDS = num_words(N, W);
    localparam int LAST_W    = N - (NUM_WORDS - 1) * W;
    localparam int CW        = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    logic [CW-1:0] cnt_r;
    logic [N-1:0]  nn_in_r;
    logic          last_slot_s;

    assign last_slot_s   = (cnt_r == CW'(NUM_WORDS - 1));
    assign last_accepted = accept && last_slot_s;
    assign nn_in         = nn_in_r;

    // Slot counter wraps to 0 after the final slot is written.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= {CW{1'b0}};
        end else if (accept) begin
            if (last_slot_s) begin
                cnt_r <= {CW{1'b0}};
            end else begin
                cnt_r <= cnt_r + CW'(1);
            end
        end
    end

    // Slot write; the final slot keeps only the low LAST_W bits of its word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            nn_in_r <= {N{1'b0}};
        end else if (accept) begin
            for (int k = 0; k < NUM_WORDS - 1; k++) begin
                if (cnt_r == CW'(k)) begin
                    nn_in_r[k*W +: W] <= s_data;
                end
            end
            if (last_slot_s) begin
                nn_in_r[N-1 -: LAST_W] <= s_data[LAST_W-1:0];
            end
        end
    end

endmodule

// File: rtl/nn_stream_feeder.sv
// Sequencer driving the nn core: fill input vector, pulse start, capture result, hand it off.
// Optional WAIT timeout with err flag is built when NN_TIMEOUT_EN is defined.
module nn_stream_feeder
    import nn_pkg::*;
#(
    parameter int N              = N_DEF,
    parameter int W              = W_DEF,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [W-1:0] s_data,
    output logic [N-1:0] nn_in,
    output logic         nn_start,
    input  logic         nn_done,
    input  logic [N-1:0] nn_out,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [N-1:0] res_data,
    output logic         err
);

    feeder_state_t state_r;
    feeder_state_t state_next_s;
    logic          s_ready_r;
    logic          nn_start_r;
    logic          res_valid_r;
    logic [N-1:0]  res_data_r;
    logic          accept_s;
    logic          last_accepted_s;
    logic          capture_s;
    logic          tmo_hit_s;
    logic          tmo_fire_s;

    assign accept_s  = s_valid && s_ready_r;
    assign s_ready   = s_ready_r;
    assign nn_start  = nn_start_r;
    assign res_valid = res_valid_r;
    assign res_data  = res_data_r;

    nn_word_packer #(
        .N (N),
        .W (W)
    ) u_packer (
        .clk           (clk),
        .rst           (rst),
        .accept        (accept_s),
        .s_data        (s_data),
        .nn_in         (nn_in),
        .last_accepted (last_accepted_s)
    );

`ifdef NN_TIMEOUT_EN
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TCW-1:0] tmo_cnt_r;
    logic           err_r;

    // Counts cycles spent in WAIT; cleared whenever the FSM is elsewhere.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_cnt_r <= {TCW{1'b0}};
        end else if (state_r == WAIT) begin
            tmo_cnt_r <= tmo_cnt_r + TCW'(1);
        end else begin
            tmo_cnt_r <= {TCW{1'b0}};
        end
    end

    assign tmo_hit_s = (tmo_cnt_r == TCW'(TIMEOUT_CYCLES - 1));

    // Error flag set on timeout, held until the result handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_r <= 1'b0;
        end else if (tmo_fire_s) begin
            err_r <= 1'b1;
        end else if (res_valid_r && res_ready) begin
            err_r <= 1'b0;
        end
    end

    assign err = err_r;
`else
    assign tmo_hit_s = 1'b0;
    assign err       = 1'b0;
`endif

    // Next-state logic; nn_done is only looked at in WAIT so a stale done is harmless.
    always_comb begin
        state_next_s = state_r;
        capture_s    = 1'b0;
        tmo_fire_s   = 1'b0;
        case (state_r)
            FILL: begin
                if (last_accepted_s) begin
                    state_next_s = LAUNCH;
                end else begin
                    state_next_s = FILL;
                end
            end
            LAUNCH: begin
                state_next_s = WAIT;
            end
            WAIT: begin
                if (nn_done) begin
                    state_next_s = HOLD;
                    capture_s    = 1'b1;
                end else if (tmo_hit_s) begin
                    state_next_s = HOLD;
                    tmo_fire_s   = 1'b1;
                end else begin
                    state_next_s = WAIT;
                end
            end
            HOLD: begin
                if (res_ready) begin
                    state_next_s = FILL;
                end else begin
                    state_next_s = HOLD;
                end
            end
            default: begin
                state_next_s = FILL;
            end
        endcase
    end

    // State and handshake outputs, all registered from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= FILL;
            s_ready_r   <= 1'b0;
            nn_start_r  <= 1'b0;
            res_valid_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            s_ready_r   <= (state_next_s == FILL);
            nn_start_r  <= (state_next_s == LAUNCH);
            res_valid_r <= (state_next_s == HOLD);
        end
    end

    // Result capture; a timeout presents an all-zero result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_data_r <= {N{1'b0}};
        end else if (capture_s) begin
            res_data_r <= nn_out;
        end else if (tmo_fire_s) begin
            res_data_r <= {N{1'b0}};
        end
    end

endmodule
